// File: rtl/instr_loader.sv
// Program-stream loader: collects a 4-byte little-endian word count, then writes that many 32-bit words to instruction memory.
// Latency: a word is written one cycle after its 4th byte is accepted; done/start appear in that same cycle for the last word.
// Backpressure: in_ready depends only on registered state (high while loading, low in S_DONE/S_ERR); in_valid low simply stalls.
module instr_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              restart,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              start
);

    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Memory capacity, kept one bit wider than N so the range check never truncates.
    localparam logic [32:0]     CAP     = 33'd1 << ADDR_W;
    localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q,      state_d;
    logic [1:0]          byte_cnt_q,   byte_cnt_d;
    logic [ADDR_W:0]     word_idx_q,   word_idx_d;
    logic [31:0]         n_q,          n_d;
    logic [23:0]         asm_q,        asm_d;
    logic                imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q,  imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;
    logic                start_q,      start_d;

    logic                xfer;
    logic [31:0]         full_word;
    logic                last_word;

    assign in_ready  = (state_q == S_LEN) || (state_q == S_DATA);
    assign xfer      = in_valid && in_ready;
    // The byte on the bus completes the group when byte_cnt_q == 3.
    assign full_word = {in_data, asm_q};
    // Index is at most CAP-1 while loading, so the +1 cannot overflow 33 bits.
    assign last_word = ({{(32-ADDR_W){1'b0}}, word_idx_q} + 33'd1) == {1'b0, n_q};

    // Next-state, byte assembly and write-strobe generation.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_idx_d   = word_idx_q;
        n_d          = n_q;
        asm_d        = asm_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        start_d      = 1'b0;

        // Shared byte gathering for header and data groups.
        if (xfer) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    asm_d[7:0]   = in_data;
                2'd1:    asm_d[15:8]  = in_data;
                2'd2:    asm_d[23:16] = in_data;
                default: asm_d        = '0;
            endcase
        end

        case (state_q)
            S_LEN: begin
                if (xfer && (byte_cnt_q == 2'd3)) begin
                    n_d        = full_word;
                    word_idx_d = '0;
                    if (full_word == 32'd0) begin
                        state_d = S_DONE;
                        start_d = 1'b1;
                    end else if ({1'b0, full_word} > CAP) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer && (byte_cnt_q == 2'd3)) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_idx_q[ADDR_W-1:0];
                    imem_wdata_d = full_word;
                    word_idx_d   = word_idx_q + IDX_ONE;
                    if (last_word) begin
                        state_d = S_DONE;
                        start_d = 1'b1;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (restart) begin
                    state_d    = S_LEN;
                    byte_cnt_d = '0;
                    word_idx_d = '0;
                    n_d        = '0;
                    asm_d      = '0;
                end
            end
            default: state_d = S_LEN;
        endcase
    end

    // State and output registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LEN;
            byte_cnt_q   <= '0;
            word_idx_q   <= '0;
            n_q          <= '0;
            asm_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_idx_q   <= word_idx_d;
            n_q          <= n_d;
            asm_q        <= asm_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            start_q      <= start_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign start      = start_q;
    assign busy       = in_ready;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: two instances (ADDR_W=10 and ADDR_W=2) driven by byte-level tasks.
// Writes, start pulses and flags are captured on the falling edge and compared with a stream-level model.
// Byte driver holds in_valid until in_ready, with bounded waits.
module tb_instr_loader;

    logic        clk;
    logic        rst       [2];
    logic        in_valid  [2];
    logic [7:0]  in_data   [2];
    logic        restart   [2];
    logic        in_ready  [2];
    logic        we        [2];
    logic [31:0] wdata     [2];
    logic        busy      [2];
    logic        done      [2];
    logic        error     [2];
    logic        start     [2];
    logic [9:0]  addr_a;
    logic [1:0]  addr_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          d;
        int          addr;
        logic [31:0] data;
        logic        dn;
        logic        st;
        logic        rdy;
    } wr_t;

    wr_t         obs[$];
    wr_t         mon_w;
    int          start_cnt [2];
    int          start_cyc [2];
    int          last_xfer [2];

    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_end;   // 0 = still loading, 1 = done, 2 = error

    instr_loader #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .imem_we(we[0]), .imem_addr(addr_a), .imem_wdata(wdata[0]),
        .restart(restart[0]), .busy(busy[0]), .done(done[0]), .error(error[0]), .start(start[0])
    );

    instr_loader #(.ADDR_W(2)) dut_small (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .imem_we(we[1]), .imem_addr(addr_b), .imem_wdata(wdata[1]),
        .restart(restart[1]), .busy(busy[1]), .done(done[1]), .error(error[1]), .start(start[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Capture writes and start pulses in the middle of each cycle.
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (we[d] === 1'b1) begin
                mon_w.d    = d;
                mon_w.addr = (d == 0) ? int'(addr_a) : int'(addr_b);
                mon_w.data = wdata[d];
                mon_w.dn   = done[d];
                mon_w.st   = start[d];
                mon_w.rdy  = in_ready[d];
                obs.push_back(mon_w);
            end
            if (start[d] === 1'b1) begin
                start_cnt[d]++;
                start_cyc[d] = cyc;
            end
        end
    end

    // Expected writes and final state from the byte stream alone.
    function automatic void build_model(input logic [7:0] bs[$], input longint cap);
        longint n;
        exp_addr.delete();
        exp_data.delete();
        exp_end = 0;
        if (bs.size() < 4) return;
        n = longint'(bs[0]) + longint'(bs[1]) * 256 + longint'(bs[2]) * 65536
            + longint'(bs[3]) * 16777216;
        if (n == 0) begin
            exp_end = 1;
        end else if (n > cap) begin
            exp_end = 2;
        end else begin
            for (int i = 0; i < n; i++) begin
                if (4 + 4 * i + 3 < bs.size()) begin
                    exp_addr.push_back(i);
                    exp_data.push_back(32'(longint'(bs[4+4*i]) + longint'(bs[5+4*i]) * 256
                        + longint'(bs[6+4*i]) * 65536 + longint'(bs[7+4*i]) * 16777216));
                end
            end
            if (exp_data.size() == n) exp_end = 1;
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int d);
        rst[d]      = 1'b1;
        in_valid[d] = 1'b0;
        restart[d]  = 1'b0;
        idle(2);
        rst[d] = 1'b0;
    endtask

    task automatic pulse_restart(input int d);
        restart[d] = 1'b1;
        idle(1);
        restart[d] = 1'b0;
    endtask

    task automatic send_byte(input int d, input logic [7:0] b, input int gap);
        int n;
        in_valid[d] = 1'b0;
        idle(gap);
        in_valid[d] = 1'b1;
        in_data[d]  = b;
        n = 0;
        while (in_ready[d] !== 1'b1 && n < 40) begin
            idle(1);
            n++;
        end
        total++;
        if (in_ready[d] !== 1'b1) begin
            bad++;
            $display("FAIL byte_accept dut%0d in_ready=%b required 1 within 40 cycles", d, in_ready[d]);
            in_valid[d] = 1'b0;
            return;
        end
        idle(1);
        last_xfer[d] = cyc;
        in_valid[d]  = 1'b0;
    endtask

    task automatic send_stream(input int d, input logic [7:0] bs[$], input int gmin, input int gmax);
        foreach (bs[i]) send_byte(d, bs[i], int'($urandom_range(gmax, gmin)));
    endtask

    task automatic clear_obs();
        obs.delete();
        start_cnt[0] = 0;
        start_cnt[1] = 0;
    endtask

    task automatic test_reset();
        rst[0] = 1'b1; rst[1] = 1'b1;
        in_valid[0] = 1'b0; in_valid[1] = 1'b0;
        restart[0] = 1'b0; restart[1] = 1'b0;
        in_data[0] = 8'h00; in_data[1] = 8'h00;
        @(posedge clk);
        idle(2);
        rst[0] = 1'b0; rst[1] = 1'b0;
        total++;
        if ({in_ready[0], busy[0], done[0], error[0], start[0], we[0]} !== 6'b110000) begin
            bad++;
            $display("FAIL reset_flags got=%b required=110000",
                     {in_ready[0], busy[0], done[0], error[0], start[0], we[0]});
        end
        total++;
        if (addr_a !== 10'd0 || wdata[0] !== 32'd0) begin
            bad++;
            $display("FAIL reset_bus addr=%h wdata=%h required 0/0", addr_a, wdata[0]);
        end
        total++;
        if ({in_ready[1], busy[1], done[1], error[1], start[1], we[1]} !== 6'b110000) begin
            bad++;
            $display("FAIL reset_flags_small got=%b required=110000",
                     {in_ready[1], busy[1], done[1], error[1], start[1], we[1]});
        end
    endtask

    task automatic test_directed(input int gap, input string tag);
        logic [7:0] bs[$];
        bs = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h33, 8'h85, 8'ha5, 8'h00};
        do_reset(0);
        clear_obs();
        send_stream(0, bs, gap, gap);
        idle(3);
        total++;
        if (obs.size() != 2 || start_cnt[0] != 1) begin
            bad++;
            $display("FAIL %s_count writes=%0d starts=%0d required 2/1", tag, obs.size(), start_cnt[0]);
        end
        if (obs.size() == 2) begin
            total++;
            if (obs[0].addr != 0 || obs[0].data !== 32'h00100513 || obs[0].dn !== 1'b0 || obs[0].st !== 1'b0) begin
                bad++;
                $display("FAIL %s_w0 addr=%0d data=%h done=%b start=%b required 0/00100513/0/0",
                         tag, obs[0].addr, obs[0].data, obs[0].dn, obs[0].st);
            end
            total++;
            if (obs[1].addr != 1 || obs[1].data !== 32'h00a58533 || obs[1].dn !== 1'b1
                || obs[1].st !== 1'b1 || obs[1].rdy !== 1'b0) begin
                bad++;
                $display("FAIL %s_w1 addr=%0d data=%h done=%b start=%b rdy=%b required 1/00a58533/1/1/0",
                         tag, obs[1].addr, obs[1].data, obs[1].dn, obs[1].st, obs[1].rdy);
            end
        end
    endtask

    task automatic test_zero_len();
        logic [7:0] bs[$];
        bs = '{8'h00, 8'h00, 8'h00, 8'h00};
        do_reset(0);
        clear_obs();
        send_stream(0, bs, 0, 1);
        idle(4);
        total++;
        if (obs.size() != 0 || done[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
            bad++;
            $display("FAIL zero_len writes=%0d done=%b ready=%b required 0/1/0", obs.size(), done[0], in_ready[0]);
        end
        total++;
        if (start_cnt[0] != 1 || start_cyc[0] != last_xfer[0]) begin
            bad++;
            $display("FAIL zero_start count=%0d at=%0d required 1 at %0d", start_cnt[0], start_cyc[0], last_xfer[0]);
        end
    endtask

    task automatic test_range();
        logic [7:0] bs[$];
        do_reset(1);
        clear_obs();
        bs = '{8'h05, 8'h00, 8'h00, 8'h00};
        send_stream(1, bs, 0, 0);
        idle(2);
        total++;
        if (error[1] !== 1'b1 || in_ready[1] !== 1'b0 || obs.size() != 0 || start_cnt[1] != 0) begin
            bad++;
            $display("FAIL range_err err=%b ready=%b writes=%0d starts=%0d required 1/0/0/0",
                     error[1], in_ready[1], obs.size(), start_cnt[1]);
        end
        pulse_restart(1);
        total++;
        if (in_ready[1] !== 1'b1 || error[1] !== 1'b0) begin
            bad++;
            $display("FAIL range_restart ready=%b err=%b required 1/0", in_ready[1], error[1]);
        end
        // Low bits say 4; a truncating check would accept this header.
        bs = '{8'h04, 8'h00, 8'h01, 8'h00};
        send_stream(1, bs, 0, 0);
        idle(2);
        total++;
        if (error[1] !== 1'b1 || obs.size() != 0) begin
            bad++;
            $display("FAIL range_wide err=%b writes=%0d required 1/0", error[1], obs.size());
        end
        pulse_restart(1);
        bs = '{8'h04, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 16; i++) bs.push_back(8'($urandom_range(255, 0)));
        build_model(bs, 4);
        send_stream(1, bs, 0, 1);
        in_valid[1] = 1'b1;
        in_data[1]  = 8'h5a;
        idle(3);
        in_valid[1] = 1'b0;
        total++;
        if (obs.size() != 4 || done[1] !== 1'b1 || start_cnt[1] != 1) begin
            bad++;
            $display("FAIL full_cap writes=%0d done=%b starts=%0d required 4/1/1", obs.size(), done[1], start_cnt[1]);
        end
        for (int i = 0; i < obs.size() && i < 4; i++) begin
            total++;
            if (obs[i].addr != exp_addr[i] || obs[i].data !== exp_data[i]) begin
                bad++;
                $display("FAIL full_cap_w%0d addr=%0d data=%h required %0d/%h",
                         i, obs[i].addr, obs[i].data, exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] bs[$];
        do_reset(0);
        clear_obs();
        bs = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        send_stream(0, bs, 0, 1);
        // Reset together with restart and a valid byte: reset must win.
        rst[0] = 1'b1; restart[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 8'h33;
        idle(1);
        rst[0] = 1'b0; restart[0] = 1'b0; in_valid[0] = 1'b0;
        idle(2);
        total++;
        if (obs.size() != 0 || in_ready[0] !== 1'b1 || done[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid writes=%0d ready=%b done=%b required 0/1/0", obs.size(), in_ready[0], done[0]);
        end
        bs = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hef, 8'hbe, 8'had, 8'hde};
        send_stream(0, bs, 0, 0);
        idle(2);
        total++;
        if (obs.size() != 1 || start_cnt[0] != 1) begin
            bad++;
            $display("FAIL reload_count writes=%0d starts=%0d required 1/1", obs.size(), start_cnt[0]);
        end else if (obs[0].addr != 0 || obs[0].data !== 32'hdeadbeef) begin
            total++;
            bad++;
            $display("FAIL reload_word addr=%0d data=%h required 0/deadbeef", obs[0].addr, obs[0].data);
        end
    endtask

    task automatic test_restart();
        logic [7:0] bs[$];
        logic [7:0] part[$];
        do_reset(0);
        clear_obs();
        bs = '{8'h03, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 12; i++) bs.push_back(8'($urandom_range(255, 0)));
        build_model(bs, 1024);
        for (int i = 0; i < 10; i++) part.push_back(bs[i]);
        send_stream(0, part, 0, 1);
        pulse_restart(0);
        total++;
        if (busy[0] !== 1'b1 || in_ready[0] !== 1'b1 || done[0] !== 1'b0) begin
            bad++;
            $display("FAIL restart_busy busy=%b ready=%b done=%b required 1/1/0", busy[0], in_ready[0], done[0]);
        end
        part.delete();
        for (int i = 10; i < 16; i++) part.push_back(bs[i]);
        send_stream(0, part, 0, 1);
        idle(2);
        total++;
        if (obs.size() != 3 || start_cnt[0] != 1) begin
            bad++;
            $display("FAIL restart_ignored writes=%0d starts=%0d required 3/1", obs.size(), start_cnt[0]);
        end
        for (int i = 0; i < obs.size() && i < 3; i++) begin
            total++;
            if (obs[i].addr != exp_addr[i] || obs[i].data !== exp_data[i]) begin
                bad++;
                $display("FAIL restart_w%0d addr=%0d data=%h required %0d/%h",
                         i, obs[i].addr, obs[i].data, exp_addr[i], exp_data[i]);
            end
        end
        pulse_restart(0);
        total++;
        if (in_ready[0] !== 1'b1 || done[0] !== 1'b0) begin
            bad++;
            $display("FAIL restart_done ready=%b done=%b required 1/0", in_ready[0], done[0]);
        end
        obs.delete();
        bs = '{8'h02, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) bs.push_back(8'($urandom_range(255, 0)));
        build_model(bs, 1024);
        send_stream(0, bs, 0, 2);
        idle(2);
        total++;
        if (obs.size() != 2 || start_cnt[0] != 2) begin
            bad++;
            $display("FAIL reload_after_done writes=%0d starts=%0d required 2/2", obs.size(), start_cnt[0]);
        end else begin
            total++;
            if (obs[0].addr != 0 || obs[0].data !== exp_data[0] || obs[1].addr != 1 || obs[1].data !== exp_data[1]) begin
                bad++;
                $display("FAIL reload_words a0=%0d d0=%h a1=%0d d1=%h required 0/%h 1/%h",
                         obs[0].addr, obs[0].data, obs[1].addr, obs[1].data, exp_data[0], exp_data[1]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] bs[$];
        longint     n;
        do_reset(0);
        for (int it = 0; it < 24; it++) begin
            clear_obs();
            if (it % 6 == 5) n = (it % 12 == 5) ? 64'd1025 : 64'd1025 + $urandom_range(4000000, 0);
            else             n = $urandom_range(6, 0);
            bs.delete();
            for (int k = 0; k < 4; k++) bs.push_back(8'((n >> (8 * k)) & 64'hff));
            if (n <= 6) for (int k = 0; k < 4 * n; k++) bs.push_back(8'($urandom_range(255, 0)));
            build_model(bs, 1024);
            send_stream(0, bs, 0, 2);
            // Bytes offered after completion must be ignored.
            in_valid[0] = 1'b1;
            in_data[0]  = 8'($urandom_range(255, 0));
            idle(3);
            in_valid[0] = 1'b0;
            total++;
            if (obs.size() != exp_data.size() || done[0] !== (exp_end == 1) || error[0] !== (exp_end == 2)
                || start_cnt[0] != ((exp_end == 1) ? 1 : 0)) begin
                bad++;
                $display("FAIL rand%0d_end n=%0d writes=%0d done=%b err=%b starts=%0d required %0d end=%0d",
                         it, n, obs.size(), done[0], error[0], start_cnt[0], exp_data.size(), exp_end);
            end
            for (int i = 0; i < obs.size() && i < exp_data.size(); i++) begin
                total++;
                if (obs[i].addr != exp_addr[i] || obs[i].data !== exp_data[i]
                    || obs[i].dn !== (i == exp_data.size() - 1) || obs[i].st !== (i == exp_data.size() - 1)) begin
                    bad++;
                    $display("FAIL rand%0d_w%0d addr=%0d data=%h done=%b start=%b required %0d/%h last=%0d",
                             it, i, obs[i].addr, obs[i].data, obs[i].dn, obs[i].st,
                             exp_addr[i], exp_data[i], i == exp_data.size() - 1);
                end
            end
            pulse_restart(0);
        end
    endtask

    initial begin
        test_reset();
        test_directed(0, "stream");
        test_directed(1, "toggle");
        test_zero_len();
        test_range();
        test_reset_mid();
        test_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
